keypad_scanner: RTL and testbench

Scans the 4x4 matrix keypad and turns raw column/row activity into debounced 4-bit key codes with a one-cycle valid strobe. It sits directly upstream of the A/B entry-and-sum FSM inside `top`. It drives the keypad `columnas` pins, reads the `filas` pins, and feeds `tecla`/`tecla_valida` to the FSM. One accepted event is produced per physical press; holding a key never repeats it.

---
 rtl/keypad_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns one-hot low, debounces row activity,
// and emits one key code with a single-cycle strobe per physical press.
//
// state       | meaning
// ------------|------------------------------------------------------------
// SCAN        | rotate columns, sample rows on the last dwell cycle
// DEB_PRESS   | column held, rows must stay equal to the captured pattern
// PRESSED     | one cycle after the accept edge; strobe is high here
// DEB_RELEASE | column held until rows read all-high long enough
module keypad_scanner #(
    parameter int SCAN_TICKS     = 27000,
    parameter int DEBOUNCE_TICKS = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] tecla,
    output logic       tecla_valida,
    output logic       tecla_presionada
);

    localparam int SW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEBOUNCE_TICKS);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [3:0]    ROWS_IDLE = 4'hF;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    logic [3:0]    filas_m_q;
    logic [3:0]    filas_s_q;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [SW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [3:0]    patron_q, patron_d;
    logic [3:0]    columnas_q, columnas_d;
    logic [3:0]    tecla_q, tecla_d;
    logic          valida_q, valida_d;
    logic          presionada_q, presionada_d;

    // Lowest-index low row wins when several rows are pulled down.
    function automatic logic [1:0] low_row(input logic [3:0] p);
        logic [1:0] r;
        if (!p[0])      r = 2'd0;
        else if (!p[1]) r = 2'd1;
        else if (!p[2]) r = 2'd2;
        else            r = 2'd3;
        return r;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] k;
        case ({row, col})
            4'h0:    k = 4'h1;
            4'h1:    k = 4'h2;
            4'h2:    k = 4'h3;
            4'h3:    k = 4'hA;
            4'h4:    k = 4'h4;
            4'h5:    k = 4'h5;
            4'h6:    k = 4'h6;
            4'h7:    k = 4'hB;
            4'h8:    k = 4'h7;
            4'h9:    k = 4'h8;
            4'hA:    k = 4'h9;
            4'hB:    k = 4'hC;
            4'hC:    k = 4'hE;
            4'hD:    k = 4'h0;
            4'hE:    k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filas_m_q <= ROWS_IDLE;
            filas_s_q <= ROWS_IDLE;
        end else begin
            filas_m_q <= filas;
            filas_s_q <= filas_m_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SCAN;
            col_q        <= 2'd0;
            dwell_q      <= '0;
            deb_q        <= '0;
            patron_q     <= ROWS_IDLE;
            columnas_q   <= 4'b1110;
            tecla_q      <= 4'h0;
            valida_q     <= 1'b0;
            presionada_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            dwell_q      <= dwell_d;
            deb_q        <= deb_d;
            patron_q     <= patron_d;
            columnas_q   <= columnas_d;
            tecla_q      <= tecla_d;
            valida_q     <= valida_d;
            presionada_q <= presionada_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        dwell_d      = dwell_q;
        deb_d        = deb_q;
        patron_d     = patron_q;
        tecla_d      = tecla_q;
        valida_d     = 1'b0;
        presionada_d = presionada_q;

        case (state_q)
            SCAN: begin
                if (dwell_q == SCAN_LAST) begin
                    dwell_d = '0;
                    if (filas_s_q == ROWS_IDLE) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        patron_d = filas_s_q;
                        deb_d    = '0;
                        state_d  = DEB_PRESS;
                    end
                end else begin
                    dwell_d = dwell_q + SW'(1);
                end
            end

            DEB_PRESS: begin
                if (filas_s_q == patron_q) begin
                    if (deb_q == DEB_LAST) begin
                        // Outputs are registered on entry so the strobe lands in PRESSED.
                        state_d      = PRESSED;
                        deb_d        = '0;
                        tecla_d      = key_code(low_row(patron_q), col_q);
                        valida_d     = 1'b1;
                        presionada_d = 1'b1;
                    end else begin
                        deb_d = deb_q + DW'(1);
                    end
                end else if (filas_s_q == ROWS_IDLE) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                    deb_d   = '0;
                end else begin
                    patron_d = filas_s_q;
                    deb_d    = '0;
                end
            end

            PRESSED: begin
                state_d = DEB_RELEASE;
                deb_d   = '0;
            end

            DEB_RELEASE: begin
                if (filas_s_q == ROWS_IDLE) begin
                    if (deb_q == DEB_LAST) begin
                        state_d      = SCAN;
                        col_d        = col_q + 2'd1;
                        dwell_d      = '0;
                        deb_d        = '0;
                        presionada_d = 1'b0;
                    end else begin
                        deb_d = deb_q + DW'(1);
                    end
                end else begin
                    deb_d = '0;
                end
            end

            default: begin
                state_d = SCAN;
                dwell_d = '0;
                deb_d   = '0;
            end
        endcase

        columnas_d = ~(4'b0001 << col_d);
    end

    assign columnas         = columnas_q;
    assign tecla            = tecla_q;
    assign tecla_valida     = valida_q;
    assign tecla_presionada = presionada_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad that only
// pulls a row low while the pressed key's column is driven low.
module tb_keypad_scanner;

    localparam int ST = 4;
    localparam int DT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] tecla;
    logic       tecla_valida;
    logic       tecla_presionada;

    logic [15:0] keys = '0;   // bit r*4+c

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         strobe_cnt = 0;
    logic [3:0] strobe_code [64];
    int         strobe_cyc  [64];
    int         strobe_gap  [64];
    int         col_change_cyc = 0;
    logic [3:0] prev_col = 4'hF;
    logic       prev_valida = 1'b0;
    bit         double_strobe = 1'b0;

    keypad_scanner #(
        .SCAN_TICKS    (ST),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .filas           (filas),
        .columnas        (columnas),
        .tecla           (tecla),
        .tecla_valida    (tecla_valida),
        .tecla_presionada(tecla_presionada)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (|(keys[r*4 +: 4] & ~columnas)) filas[r] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (columnas !== prev_col) col_change_cyc = cyc;
        prev_col = columnas;
        if (tecla_valida === 1'b1) begin
            if (prev_valida) double_strobe = 1'b1;
            if (strobe_cnt < 64) begin
                strobe_code[strobe_cnt] = tecla;
                strobe_cyc[strobe_cnt]  = cyc;
                strobe_gap[strobe_cnt]  = cyc - col_change_cyc;
            end
            strobe_cnt++;
        end
        prev_valida = (tecla_valida === 1'b1);
    end

    task automatic test_reset();
        rst  = 1'b0;
        keys = '0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (columnas !== 4'b1110) begin
            n_fail++; $display("FAIL reset_columnas: got %b expected 1110", columnas);
        end
        n_checks++;
        if (tecla !== 4'h0) begin
            n_fail++; $display("FAIL reset_tecla: got %h expected 0", tecla);
        end
        n_checks++;
        if (tecla_valida !== 1'b0) begin
            n_fail++; $display("FAIL reset_valida: got %b expected 0", tecla_valida);
        end
        n_checks++;
        if (tecla_presionada !== 1'b0) begin
            n_fail++; $display("FAIL reset_presionada: got %b expected 0", tecla_presionada);
        end
    endtask

    task automatic test_idle_rotation();
        int base;
        logic [3:0] one;
        logic [3:0] exp_col;
        one  = 4'b0001;
        base = strobe_cnt;
        rst  = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            exp_col = ~(one << ((k >> 2) % 4));
            n_checks++;
            if (columnas !== exp_col) begin
                n_fail++; $display("FAIL idle_rotation k=%0d: got %b expected %b", k, columnas, exp_col);
            end
        end
        repeat (168) @(negedge clk);
        n_checks++;
        if (strobe_cnt != base) begin
            n_fail++; $display("FAIL idle_no_strobe: got %0d strobes expected 0", strobe_cnt - base);
        end
    endtask

    task automatic test_sequence();
        int base;
        int seq_idx [4];
        logic [3:0] seq_code [4];
        seq_idx  = '{0, 1, 2, 14};
        seq_code = '{4'h1, 4'h2, 4'h3, 4'hF};
        base = strobe_cnt;
        for (int i = 0; i < 4; i++) begin
            keys = '0;
            keys[seq_idx[i]] = 1'b1;
            repeat (40) @(negedge clk);
            n_checks++;
            if (tecla_presionada !== 1'b1) begin
                n_fail++; $display("FAIL seq_held_presionada key%0d: got %b expected 1", i, tecla_presionada);
            end
            repeat (20) @(negedge clk);
            keys = '0;
            repeat (60) @(negedge clk);
            n_checks++;
            if (tecla_presionada !== 1'b0) begin
                n_fail++; $display("FAIL seq_released_presionada key%0d: got %b expected 0", i, tecla_presionada);
            end
        end
        n_checks++;
        if (strobe_cnt - base != 4) begin
            n_fail++; $display("FAIL seq_strobe_count: got %0d expected 4", strobe_cnt - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (strobe_code[base+i] !== seq_code[i]) begin
                    n_fail++; $display("FAIL seq_code %0d: got %h expected %h", i, strobe_code[base+i], seq_code[i]);
                end
                n_checks++;
                if (strobe_gap[base+i] != ST + DT) begin
                    n_fail++; $display("FAIL seq_latency %0d: got %0d expected %0d cycles from column start", i, strobe_gap[base+i], ST + DT);
                end
            end
        end
    endtask

    task automatic wait_col_start(input logic [3:0] target, output bit found);
        logic [3:0] prev;
        prev  = columnas;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (columnas === target && prev !== target) found = 1'b1;
            prev = columnas;
        end
    endtask

    task automatic test_bounce();
        int base;
        bit found;
        logic [3:0] exp_col [7];
        exp_col = '{4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b0111};
        base = strobe_cnt;
        wait_col_start(4'b1101, found);
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL bounce_col1_timeout: got no column 1 start expected one within 40 cycles");
        end
        keys[5] = 1'b1;
        repeat (3) @(negedge clk);
        keys = '0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            n_checks++;
            if (columnas !== exp_col[j]) begin
                n_fail++; $display("FAIL bounce_columnas +%0d: got %b expected %b", j + 4, columnas, exp_col[j]);
            end
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (strobe_cnt != base) begin
            n_fail++; $display("FAIL bounce_no_strobe: got %0d strobes expected 0", strobe_cnt - base);
        end
    endtask

    task automatic test_hold();
        int base;
        base = strobe_cnt;
        keys[12] = 1'b1;
        repeat (300) @(negedge clk);
        n_checks++;
        if (strobe_cnt - base != 1) begin
            n_fail++; $display("FAIL hold_strobe_count: got %0d expected 1", strobe_cnt - base);
        end
        n_checks++;
        if (strobe_code[base] !== 4'hE) begin
            n_fail++; $display("FAIL hold_code: got %h expected e", strobe_code[base]);
        end
        n_checks++;
        if (tecla_presionada !== 1'b1) begin
            n_fail++; $display("FAIL hold_presionada: got %b expected 1", tecla_presionada);
        end
        keys = '0;
        repeat (9) @(negedge clk);
        n_checks++;
        if (tecla_presionada !== 1'b1) begin
            n_fail++; $display("FAIL hold_release_early: got %b expected 1 at release+9", tecla_presionada);
        end
        @(negedge clk);
        n_checks++;
        if (tecla_presionada !== 1'b0) begin
            n_fail++; $display("FAIL hold_release_fall: got %b expected 0 at release+10", tecla_presionada);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_priority_rollover();
        int base;
        int rel_cyc;
        base = strobe_cnt;
        keys[4] = 1'b1;
        keys[8] = 1'b1;
        repeat (60) @(negedge clk);
        n_checks++;
        if (strobe_cnt - base != 1) begin
            n_fail++; $display("FAIL prio_strobe_count: got %0d expected 1", strobe_cnt - base);
        end
        n_checks++;
        if (tecla !== 4'h4) begin
            n_fail++; $display("FAIL prio_code: got %h expected 4", tecla);
        end
        keys[10] = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++;
        if (strobe_cnt - base != 1) begin
            n_fail++; $display("FAIL rollover_ignored: got %0d strobes expected 1", strobe_cnt - base);
        end
        keys[4] = 1'b0;
        keys[8] = 1'b0;
        rel_cyc = cyc;
        repeat (60) @(negedge clk);
        n_checks++;
        if (strobe_cnt - base != 2) begin
            n_fail++; $display("FAIL rollover_after_release: got %0d strobes expected 2", strobe_cnt - base);
        end else begin
            n_checks++;
            if (strobe_code[base+1] !== 4'h9) begin
                n_fail++; $display("FAIL rollover_code: got %h expected 9", strobe_code[base+1]);
            end
            n_checks++;
            if (strobe_cyc[base+1] - rel_cyc != 26) begin
                n_fail++; $display("FAIL rollover_timing: got %0d expected 26 cycles after release", strobe_cyc[base+1] - rel_cyc);
            end
        end
        keys = '0;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_reset_mid_debounce();
        int base;
        bit found;
        logic [3:0] one;
        logic [3:0] exp_col;
        one  = 4'b0001;
        base = strobe_cnt;
        wait_col_start(4'b1101, found);
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL rstmid_col1_timeout: got no column 1 start expected one within 40 cycles");
        end
        keys[1] = 1'b1;
        repeat (7) @(negedge clk);
        n_checks++;
        if (columnas !== 4'b1101) begin
            n_fail++; $display("FAIL rstmid_held_column: got %b expected 1101", columnas);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (columnas !== 4'b1110) begin
            n_fail++; $display("FAIL rstmid_columnas: got %b expected 1110", columnas);
        end
        n_checks++;
        if (tecla !== 4'h0) begin
            n_fail++; $display("FAIL rstmid_tecla: got %h expected 0", tecla);
        end
        n_checks++;
        if (tecla_valida !== 1'b0 || tecla_presionada !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_flags: got %b%b expected 00", tecla_valida, tecla_presionada);
        end
        keys = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_col = ~(one << ((k >> 2) % 4));
            n_checks++;
            if (columnas !== exp_col) begin
                n_fail++; $display("FAIL rstmid_restart k=%0d: got %b expected %b", k, columnas, exp_col);
            end
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (strobe_cnt != base) begin
            n_fail++; $display("FAIL rstmid_no_strobe: got %0d strobes expected 0", strobe_cnt - base);
        end
    endtask

    task automatic test_strobe_width();
        n_checks++;
        if (double_strobe) begin
            n_fail++; $display("FAIL strobe_width: got back-to-back strobe expected single-cycle");
        end
        n_checks++;
        if (strobe_cnt != 7) begin
            n_fail++; $display("FAIL total_strobes: got %0d expected 7", strobe_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_idle_rotation();
        test_sequence();
        test_bounce();
        test_hold();
        test_priority_rollover();
        test_reset_mid_debounce();
        test_strobe_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
